// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the multi-cycle ALU.
package alu_pkg;
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_ANDN = 3'd4;
   localparam logic [2:0] OP_ORN  = 3'd5;
   localparam logic [2:0] OP_SUB  = 3'd6;
   localparam logic [2:0] OP_SLT  = 3'd7;
   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle; done flags the final step,
// whose product is presented combinationally on prod.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] mcand, mplier, acc, step;
   logic [CW-1:0]    cnt;
   logic             busy;
   always_comb step = acc + (mplier[0] ? mcand : '0);
   assign done = busy && cnt == CW'(WIDTH - 1);
   assign prod = step;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (busy) begin
         acc    <= step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         busy   <= !done;
      end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready in and out; ALU_MUL_EN enables the iterative
// multiplier for opcode 3, otherwise opcode 3 is reported as illegal in one cycle.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_err
);
   state_t           state, state_nxt;
   logic             accept, load, is_mul, mul_done;
   logic             c_res, v_res, e_res, add_ovf, sub_ovf;
   logic [WIDTH-1:0] res, fin, mul_prod;
   logic [WIDTH:0]   sum, diff;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
   end

   always_comb begin
      res   = '0;
      c_res = 1'b0;
      v_res = 1'b0;
      e_res = 1'b0;
      case (sel)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  begin res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; v_res = add_ovf; end
`ifdef ALU_MUL_EN
         OP_MUL:  res = '0;
`else
         OP_MUL:  e_res = 1'b1;
`endif
         OP_ANDN: res = a & ~b;
         OP_ORN:  res = a | ~b;
         OP_SUB:  begin res = diff[WIDTH-1:0]; c_res = !diff[WIDTH]; v_res = sub_ovf; end
         OP_SLT:  res = WIDTH'(diff[WIDTH-1] ^ sub_ovf);
      endcase
   end

`ifdef ALU_MUL_EN
   assign is_mul = sel == OP_MUL;
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && is_mul),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`else
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_prod = '0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (state == ST_IDLE && accept && is_mul) state_nxt = ST_MUL;
      else if (state == ST_MUL && mul_done)     state_nxt = ST_IDLE;
   end

   // An accept and a drain may share an edge, sustaining one op per clock.
   always_comb begin
      in_ready = rst_n && state == ST_IDLE && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
      load     = (accept && !is_mul) || (state == ST_MUL && mul_done);
      fin      = (state == ST_MUL) ? mul_prod : res;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_zero  <= 1'b0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out       <= fin;
         out_zero  <= fin == '0;
         out_carry <= state == ST_IDLE && c_res;
         out_ovf   <= state == ST_IDLE && v_res;
         out_err   <= state == ST_IDLE && e_res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc (WIDTH=32); inputs change on the falling edge and
// outputs are sampled there. Multiplier checks run when ALU_MUL_EN is defined.
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  sel = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out;
   logic        out_zero, out_carry, out_ovf, out_err;
   int          n_chk = 0;
   int          n_fail = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_zero  (out_zero),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting edge.
   task automatic send(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      sel = s; a = x; b = y; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_res(input string t, input logic [31:0] o, input logic [3:0] f);
      check({t, "_valid"}, out_valid, 1);
      check({t, "_out"}, out, o);
      check({t, "_flags"}, {out_zero, out_carry, out_ovf, out_err}, f);
   endtask

   initial begin
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // flags order: {zero, carry, ovf, err}
      send(3'd2, 32'hFFFF_FFFF, 32'h1);       expect_res("add_carry", 32'h0, 4'b1100);
      send(3'd2, 32'h7FFF_FFFF, 32'h1);       expect_res("add_ovf", 32'h8000_0000, 4'b0010);
      send(3'd6, 32'h3, 32'h5);               expect_res("sub_neg", 32'hFFFF_FFFE, 4'b0000);
      send(3'd6, 32'h5, 32'h3);               expect_res("sub_pos", 32'h2, 4'b0100);
      send(3'd6, 32'h8000_0000, 32'h1);       expect_res("sub_ovf", 32'h7FFF_FFFF, 4'b0110);
      send(3'd7, 32'hFFFF_FFFF, 32'h1);       expect_res("slt_m1_1", 32'h1, 4'b0000);
      send(3'd7, 32'h1, 32'hFFFF_FFFF);       expect_res("slt_1_m1", 32'h0, 4'b1000);
      send(3'd7, 32'h8000_0000, 32'h1);       expect_res("slt_ovf", 32'h1, 4'b0000);
      send(3'd0, 32'hF0F0_00FF, 32'hFF00_0F0F); expect_res("and", 32'hF000_000F, 4'b0000);
      send(3'd1, 32'hF0F0_00FF, 32'hFF00_0F0F); expect_res("or", 32'hFFF0_0FFF, 4'b0000);
      send(3'd4, 32'hF0F0_00FF, 32'hFF00_0F0F); expect_res("andn", 32'h00F0_00F0, 4'b0000);
      send(3'd5, 32'hF0F0_00FF, 32'hFF00_0F0F); expect_res("orn", 32'hF0FF_F0FF, 4'b0000);
      @(negedge clk);
      check("drain_valid", out_valid, 0);

`ifdef ALU_MUL_EN
      begin
         int cyc = 0;
         send(3'd3, 32'h0001_0003, 32'h0000_0005);
         sel = 3'd2; a = 32'h1; b = 32'h1; in_valid = 1'b1;
         #1;
         check("mul_busy_ready", in_ready, 0);
         check("mul_busy_valid", out_valid, 0);
         while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         in_valid = 1'b0;
         check("mul_latency", 64'(cyc), 32);
         expect_res("mul", 32'h0005_000F, 4'b0000);
         @(negedge clk);
         check("mul_no_extra", out_valid, 0);
         send(3'd3, 32'h1234, 32'h10);
         repeat (5) @(negedge clk);
         #2 rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         repeat (40) @(negedge clk);
         check("mul_abort", out_valid, 0);
      end
`else
      send(3'd3, 32'h5, 32'h7);               expect_res("mul_err", 32'h0, 4'b1001);
`endif
      send(3'd2, 32'h2, 32'h3);               expect_res("add_after", 32'h5, 4'b0000);
      @(negedge clk);

      // Backpressure: four ANDs with the consumer stalled for three cycles.
      out_ready = 1'b0;
      sel = 3'd0; a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; in_valid = 1'b1;
      @(negedge clk);
      a = 32'hAAAA_AAAA; b = 32'h0000_FFFF;
      check("bp_ready1", in_ready, 0);
      expect_res("bp_hold1", 32'h0F0F_0000, 4'b0000);
      @(negedge clk);
      check("bp_ready2", in_ready, 0);
      expect_res("bp_hold2", 32'h0F0F_0000, 4'b0000);
      @(negedge clk);
      check("bp_ready3", in_ready, 0);
      expect_res("bp_r0", 32'h0F0F_0000, 4'b0000);
      out_ready = 1'b1;
      @(negedge clk);
      expect_res("bp_r1", 32'h0000_AAAA, 4'b0000);
      a = 32'h1234_5678; b = 32'hF0F0_F0F0;
      @(negedge clk);
      expect_res("bp_r2", 32'h1030_5070, 4'b0000);
      a = 32'hFFFF_FFFF; b = 32'h89AB_CDEF;
      @(negedge clk);
      expect_res("bp_r3", 32'h89AB_CDEF, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_empty", out_valid, 0);

      // Asynchronous reset while a result is held.
      out_ready = 1'b0;
      send(3'd2, 32'hFFFF_FFFF, 32'h1);
      expect_res("pre_rst", 32'h0, 4'b1100);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_out", out, 0);
      check("arst_flags", {out_zero, out_carry, out_ovf, out_err}, 0);
      check("arst_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      send(3'd1, 32'h0, 32'h0);               expect_res("post_rst", 32'h0, 4'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
